bcd_add_seq: RTL
================

# bcd_add_seq

Sequential multi-digit packed-BCD adder that processes one decimal digit per clock, least-significant digit first. It is the additive counterpart of the BCD subtraction datapath and produces operands and results in the same packed 4-bit-per-digit format, so the two can be chained or cross-checked. A start/done handshake frames each operation. Results are held stable until the next operation completes.

## Interface
- DIGITS, 4: number of BCD digits per operand; W = 4*DIGITS.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE or DONE.
- a  in  W  packed BCD operand A; digit 0 is a[3:0].
- b  in  W  packed BCD operand B.
- cin  in  1  decimal carry into digit 0.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  high for exactly the one cycle spent in DONE.
- sum  out  W  packed BCD result, registered.
- cout  out  1  decimal carry out of digit DIGITS-1.
- err  out  1  at least one nibble of a or b was greater than 9 in the completed operation.

## Operation
- State machine: IDLE, ADD, DONE.
  - IDLE goes to ADD when start=1.
  - ADD stays in ADD while idx < DIGITS-1, then goes to DONE.
  - DONE goes to ADD when start=1, otherwise to IDLE.
- Start acceptance (IDLE or DONE):
  - latch a, b and cin into internal registers;
  - clear idx, the accumulator and the error flag;
  - start in ADD is ignored, and a, b and cin changes during ADD have no effect.
- Per ADD cycle, with digit d = idx:
  - t = A[d] + B[d] + c, computed 5 bits wide; c is the latched cin on d=0, the previous digit's carry otherwise.
  - If t > 9: the digit is (t+6)[3:0] and the next carry is 1. Otherwise the digit is t[3:0] and the next carry is 0.
  - Write the digit to accumulator nibble d.
  - OR into the error flag whether A[d] > 9 or B[d] > 9.
  - Increment idx.
- Invalid digits: the computation still uses the rule above, so the result is deterministic but not meaningful BCD, and err is reported.
- On the transition into DONE, in the same edge as the last digit: sum <= accumulator with the final digit, cout <= final carry, err <= error flag.
- sum, cout and err change only on that transition or on reset.
- Reset: in the same edge, state becomes IDLE and idx and all internal registers are cleared. sum=0, cout=0, err=0, busy=0, done=0. An operation in progress is abandoned with no done pulse.

## Timing
- start is accepted at edge k. ADD occupies the cycles after edges k .. k+DIGITS-1.
- done=1 and new sum/cout/err are visible after edge k+DIGITS. Latency is DIGITS cycles from the accepting edge to done.
- busy=1 after edge k through the DONE cycle. It falls after edge k+DIGITS+1 unless start is accepted there.
- Back-to-back: start held high during DONE is accepted at edge k+DIGITS+1. busy stays 1, and done pulses every DIGITS+1 cycles.
- The previous sum remains valid on the outputs during the next operation's ADD cycles.
- If rst and start are both high at the same edge, reset wins.

## Test plan
- a=0432, b=0357, cin=0, start one cycle: done exactly 4 cycles after acceptance, with sum=0789, cout=0, err=0.
- a=9999, b=0001, cin=0: sum=0000, cout=1, err=0.
- a=0499, b=0500, cin=1: carry ripples through three digits, giving sum=1000, cout=0.
- a=00A0, b=0001: err=1, with sum and cout per the digit rule (sum=0101, cout=0); a following valid operation clears err to 0.
- Pulse start mid-ADD with different a/b: it is ignored, and the original result and single done pulse are unchanged. Then hold start high through DONE: a second result arrives 5 cycles after the first.
- Assert rst during ADD idx=2: the next cycle shows busy=0, done=0, sum=0; no done pulse follows. A fresh start then completes normally.

Source files
------------

// File: rtl/bcd_add_seq.sv
// Sequential packed-BCD adder: one decimal digit per clock, least-significant
// digit first. Operands are captured on start; the result registers (sum,
// cout, err) update only on the edge that completes the last digit.
//
// Handshake: start is sampled only while the machine is in IDLE or DONE and is
// accepted on that edge (operands latched, busy rises). done is high for the
// single cycle spent in DONE, during which sum/cout/err are freshly valid.
// Holding start high through DONE chains the next operation with no idle gap.
module bcd_add_seq #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  err
);

    localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic                  accept;

    logic [IDXW-1:0]       idx;
    logic [4*DIGITS-1:0]   a_q;
    logic [4*DIGITS-1:0]   b_q;
    logic                  carry_q;
    logic [4*DIGITS-1:0]   acc;
    logic                  err_q;

    logic [3:0]            dig_a;
    logic [3:0]            dig_b;
    logic [4:0]            t;
    logic [3:0]            digit;
    logic                  carry_next;
    logic                  bad;
    logic [4*DIGITS-1:0]   acc_next;

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode, start acceptance and status outputs.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        busy       = (state != IDLE);
        done       = (state == DONE);
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = ADD;
                end
            end
            ADD: begin
                if (idx == LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = ADD;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // One decimal digit step: binary add, then +6 correction when above 9.
    // Invalid nibbles go through the same rule so the result stays deterministic.
    always_comb begin
        dig_a    = a_q[4*idx +: 4];
        dig_b    = b_q[4*idx +: 4];
        t        = {1'b0, dig_a} + {1'b0, dig_b} + {4'b0000, carry_q};
        digit    = t[3:0];
        carry_next = 1'b0;
        if (t > 5'd9) begin
            digit      = t[3:0] + 4'd6;
            carry_next = 1'b1;
        end
        bad      = (dig_a > 4'd9) || (dig_b > 4'd9);
        acc_next = acc;
        acc_next[4*idx +: 4] = digit;
    end

    // Operand capture, digit accumulation and result publication on the last digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            acc     <= '0;
            err_q   <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            err     <= 1'b0;
        end else if (accept) begin
            idx     <= '0;
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            acc     <= '0;
            err_q   <= 1'b0;
        end else if (state == ADD) begin
            acc     <= acc_next;
            carry_q <= carry_next;
            err_q   <= err_q | bad;
            idx     <= idx + 1'b1;
            if (idx == LAST) begin
                sum  <= acc_next;
                cout <= carry_next;
                err  <= err_q | bad;
            end
        end
    end

endmodule
